// File: rtl/apb3_requester_pkg.sv
// Shared types for the APB3 requester: FSM state encoding and command/response records.
package apb3_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb3_req_state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } apb3_cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              error;
  } apb3_rsp_t;

endpackage

// File: rtl/apb3_requester_if.sv
// Command/response handshake plus APB3 bus signals seen by the requester.
interface apb3_requester_if #(
  parameter int AddressWidth = 8,
  parameter int DataWidth    = 32
);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [AddressWidth-1:0] cmd_addr;
  logic [DataWidth-1:0]    cmd_wdata;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DataWidth-1:0]    rsp_rdata;
  logic                    rsp_error;

  logic [AddressWidth-1:0] paddr;
  logic                    pwrite;
  logic                    psel;
  logic                    penable;
  logic [DataWidth-1:0]    pwdata;
  logic [DataWidth-1:0]    prdata;
  logic                    pready;
  logic                    pslverr;

  // master is the requester itself; slave is everything around it
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    output paddr, pwrite, psel, penable, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    input  paddr, pwrite, psel, penable, pwdata
  );

endinterface

// File: rtl/apb3_requester_watchdog.sv
// ACCESS-phase wait counter; expired flags the last wait cycle before the limit is reached.
module apb3_req_watchdog #(
  parameter int TimeoutCycles = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CountWidth = $clog2(TimeoutCycles + 1);

  logic [CountWidth-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  // Incrementing on this cycle brings the count to TimeoutCycles
  assign expired = (count == CountWidth'(TimeoutCycles - 1));

endmodule

// File: rtl/apb3_requester.sv
// Valid/ready command to APB3 requester bridge, one transfer in flight at a time.
// Define APB3_REQ_TIMEOUT_EN to abort ACCESS after TimeoutCycles wait cycles.
module apb3_requester
  import apb3_pkg::*;
#(
  parameter int AddressWidth  = 8,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  apb3_requester_if.master bus
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SETUP  = SETUP;
  localparam logic [1:0] ST_ACCESS = ACCESS;
  localparam logic [1:0] ST_RESP   = RESP;

  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("apb3_requester: TimeoutCycles must be at least 1");
  end

  logic [1:0]              state;
  logic [AddressWidth-1:0] paddr_q;
  logic                    pwrite_q;
  logic                    psel_q;
  logic                    penable_q;
  logic [DataWidth-1:0]    pwdata_q;
  logic                    rsp_valid_q;
  logic [DataWidth-1:0]    rsp_rdata_q;
  logic                    rsp_error_q;
  logic                    timeout_abort;

`ifdef APB3_REQ_TIMEOUT_EN
  logic wd_expired;

  apb3_req_watchdog #(
    .TimeoutCycles(TimeoutCycles)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == ST_SETUP),
    .inc    ((state == ST_ACCESS) && !bus.pready),
    .expired(wd_expired)
  );

  // A pready on the limit cycle still completes the transfer normally
  assign timeout_abort = wd_expired && !bus.pready;
`else
  assign timeout_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            paddr_q  <= bus.cmd_addr;
            pwrite_q <= bus.cmd_write;
            pwdata_q <= bus.cmd_write ? bus.cmd_wdata : '0;
            psel_q   <= 1'b1;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (bus.pready) begin
            rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
            rsp_error_q <= bus.pslverr;
            rsp_valid_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state       <= ST_RESP;
          end else if (timeout_abort) begin
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b1;
            rsp_valid_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // cmd_ready stays low while reset is held even though the state reads IDLE
  assign bus.cmd_ready = rst_n && (state == ST_IDLE);
  assign bus.paddr     = paddr_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;

endmodule
